// File: rtl/bc_moment_acc.sv
// bc_moment_acc: scans one bank of the box-count RAM for a 2^s x 2^s grid and
//   accumulates occupied-box count, sum of counts and sum of squared counts.
// Latency: done pulses in cycle N+2 after the start cycle (N = 4^s reads, one per cycle).
// Backpressure: none; start is ignored while busy, and results hold until the next accepted start.
//
// Build option: define BC_MAX_TRACK_EN to build the running-maximum register
//   (max_val); otherwise max_val is tied to zero.
//
// Ports:
//   CLK, RST           clock and synchronous active-high reset
//   start, bank        scan request and RAM bank to scan
//   side_log           log2 of grid side, clamped to BOX_IDX
//   rd_addr, rd_data   RAM read port, data valid one cycle after the address
//   busy, done         scan in progress / one-cycle completion pulse
//   occ_cnt, sum,      accumulated statistics, held after done
//   sum_sq, max_val
module bc_moment_acc #(
  parameter int BOX_IDX  = 3,
  parameter int DATA_LEN = 8,
  parameter int OCC_LEN  = 2*BOX_IDX+1
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic                           start,
  input  logic                           bank,
  input  logic [BOX_IDX:0]               side_log,
  output logic [2*BOX_IDX:0]             rd_addr,
  input  logic [DATA_LEN-1:0]            rd_data,
  output logic                           busy,
  output logic                           done,
  output logic [OCC_LEN-1:0]             occ_cnt,
  output logic [DATA_LEN+2*BOX_IDX-1:0]  sum,
  output logic [2*DATA_LEN+2*BOX_IDX-1:0] sum_sq,
  output logic [DATA_LEN-1:0]            max_val
);

  localparam int SUMW = DATA_LEN + 2*BOX_IDX;
  localparam int SQW  = 2*DATA_LEN + 2*BOX_IDX;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [BOX_IDX:0] S_MAX = (BOX_IDX+1)'(BOX_IDX);

  logic [1:0]            state;
  logic [BOX_IDX-1:0]    x_cnt;
  logic [BOX_IDX-1:0]    y_cnt;
  logic                  bank_q;
  logic [BOX_IDX:0]      s_q;
  logic                  vld;       // rd_data this cycle answers an address issued last cycle
  logic [BOX_IDX-1:0]    side_m1;   // 2^s - 1, the last coordinate on each axis
  logic [BOX_IDX:0]      s_clamp;
  logic                  accept;
  logic                  last_x;
  logic                  last_y;
  logic [2*DATA_LEN-1:0] sq;

  assign s_clamp = (side_log > S_MAX) ? S_MAX : side_log;
  assign accept  = start && ((state == IDLE) || (state == DONE));

  // Thermometer mask: bit i set when i < s, giving 2^s - 1 without a shifter.
  always_comb begin
    side_m1 = '0;
    for (int i = 0; i < BOX_IDX; i++) begin
      side_m1[i] = ((BOX_IDX+1)'(i) < s_q);
    end
  end

  assign last_x = (x_cnt == side_m1);
  assign last_y = (y_cnt == side_m1);

  // Counters freeze after the final address, so rd_addr holds outside READ.
  assign rd_addr = {x_cnt, bank_q, y_cnt};
  assign busy    = (state == READ) || (state == DRAIN);
  assign done    = (state == DONE);

  assign sq = (2*DATA_LEN)'(rd_data) * (2*DATA_LEN)'(rd_data);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      x_cnt   <= '0;
      y_cnt   <= '0;
      bank_q  <= 1'b0;
      s_q     <= '0;
      vld     <= 1'b0;
      occ_cnt <= '0;
      sum     <= '0;
      sum_sq  <= '0;
    end else begin
      vld <= (state == READ);

      case (state)
        IDLE, DONE: begin
          if (start) begin
            state  <= READ;
            bank_q <= bank;
            s_q    <= s_clamp;
            x_cnt  <= '0;
            y_cnt  <= '0;
          end else begin
            state <= IDLE;
          end
        end
        READ: begin
          if (last_x && last_y) begin
            state <= DRAIN;
          end else if (last_x) begin
            x_cnt <= '0;
            y_cnt <= y_cnt + 1'b1;
          end else begin
            x_cnt <= x_cnt + 1'b1;
          end
        end
        DRAIN:   state <= DONE;
        default: state <= IDLE;
      endcase

      if (accept) begin
        occ_cnt <= '0;
        sum     <= '0;
        sum_sq  <= '0;
      end else if (vld) begin
        occ_cnt <= occ_cnt + OCC_LEN'(rd_data != '0);
        sum     <= sum + SUMW'(rd_data);
        sum_sq  <= sum_sq + SQW'(sq);
      end
    end
  end

`ifdef BC_MAX_TRACK_EN
  logic [DATA_LEN-1:0] max_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      max_q <= '0;
    end else if (accept) begin
      max_q <= '0;
    end else if (vld && (rd_data > max_q)) begin
      max_q <= rd_data;
    end
  end

  assign max_val = max_q;
`else
  assign max_val = '0;
`endif

endmodule

// File: tb/tb_bc_moment_acc.sv
// tb_bc_moment_acc: directed and randomized scans of bc_moment_acc against a
//   reference model that walks the grid in raster order with plain arithmetic.
// Ports of the design are driven from one initial block; the RAM is a small array model.
module tb_bc_moment_acc;

  localparam int BI = 3;
  localparam int DL = 8;
  localparam int OL = 2*BI+1;
  localparam int AW = 2*BI+1;

  logic              CLK;
  logic              RST;
  logic              start;
  logic              bank;
  logic [BI:0]       side_log;
  logic [AW-1:0]     rd_addr;
  logic [DL-1:0]     rd_data;
  logic              busy;
  logic              done;
  logic [OL-1:0]     occ_cnt;
  logic [DL+2*BI-1:0]   sum;
  logic [2*DL+2*BI-1:0] sum_sq;
  logic [DL-1:0]     max_val;

  logic [DL-1:0] mem [0:(1<<AW)-1];

  int n_chk  = 0;
  int n_pass = 0;

  bc_moment_acc #(.BOX_IDX(BI), .DATA_LEN(DL), .OCC_LEN(OL)) dut (
    .CLK(CLK), .RST(RST), .start(start), .bank(bank), .side_log(side_log),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .occ_cnt(occ_cnt), .sum(sum), .sum_sq(sum_sq), .max_val(max_val)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Synchronous-read RAM: data appears one cycle after the address.
  always @(posedge CLK) rd_data <= mem[rd_addr];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".busy"},    64'(busy),    64'd0);
    chk({tag, ".done"},    64'(done),    64'd0);
    chk({tag, ".rd_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, ".occ"},     64'(occ_cnt), 64'd0);
    chk({tag, ".sum"},     64'(sum),     64'd0);
    chk({tag, ".sum_sq"},  64'(sum_sq),  64'd0);
    chk({tag, ".max"},     64'(max_val), 64'd0);
  endtask

  // One full scan. chained: start was already raised by the previous scan's
  // done cycle. extra_cyc: cycle in which a stray start is pulsed mid-scan.
  // b2b: raise start in the done cycle with next_s/next_bk and return.
  task automatic scan(input int s_req, input bit bk, input int extra_cyc,
                      input bit chained, input bit b2b, input int next_s,
                      input bit next_bk, input string tag);
    int se;
    int side;
    int n;
    longint e_occ;
    longint e_sum;
    longint e_sq;
    longint e_max;
    longint d;
    logic [AW-1:0] a;
    logic [AW-1:0] exp_addr[$];

    se    = (s_req > BI) ? BI : s_req;
    side  = 1 << se;
    n     = side * side;
    e_occ = 0; e_sum = 0; e_sq = 0; e_max = 0;
    for (int y = 0; y < side; y++) begin
      for (int x = 0; x < side; x++) begin
        a = AW'((x << (BI+1)) | (int'(bk) << BI) | y);
        exp_addr.push_back(a);
        d = longint'(mem[a]);
        e_sum += d;
        e_sq  += d * d;
        if (d != 0) e_occ++;
        if (d > e_max) e_max = d;
      end
    end
`ifndef BC_MAX_TRACK_EN
    e_max = 0;
`endif

    if (!chained) begin
      @(negedge CLK);
      side_log = (BI+1)'(s_req);
      bank     = bk;
      start    = 1'b1;
    end
    @(posedge CLK); #1;
    start = 1'b0;

    for (int c = 1; c <= n + 2; c++) begin
      if (c > 1) begin
        @(posedge CLK); #1;
        start = 1'b0;
      end
      chk($sformatf("%s.busy@%0d", tag, c), 64'(busy), 64'(c <= n + 1));
      chk($sformatf("%s.done@%0d", tag, c), 64'(done), 64'(c == n + 2));
      if (c <= n)
        chk($sformatf("%s.addr@%0d", tag, c), 64'(rd_addr), 64'(exp_addr[c-1]));
      if (c == 1) begin
        chk({tag, ".clr_occ"}, 64'(occ_cnt), 64'd0);
        chk({tag, ".clr_sum"}, 64'(sum),     64'd0);
        chk({tag, ".clr_sq"},  64'(sum_sq),  64'd0);
        chk({tag, ".clr_max"}, 64'(max_val), 64'd0);
      end
      if (c == extra_cyc) begin
        start    = 1'b1;
        side_log = '0;
        bank     = ~bk;
      end
    end

    chk({tag, ".occ"},    64'(occ_cnt), 64'(e_occ));
    chk({tag, ".sum"},    64'(sum),     64'(e_sum));
    chk({tag, ".sum_sq"}, 64'(sum_sq),  64'(e_sq));
    chk({tag, ".max"},    64'(max_val), 64'(e_max));

    if (b2b) begin
      side_log = (BI+1)'(next_s);
      bank     = next_bk;
      start    = 1'b1;
    end else begin
      @(posedge CLK); #1;
      chk({tag, ".done_off"}, 64'(done),    64'd0);
      chk({tag, ".idle"},     64'(busy),    64'd0);
      chk({tag, ".hold_occ"}, 64'(occ_cnt), 64'(e_occ));
      chk({tag, ".hold_sum"}, 64'(sum),     64'(e_sum));
      chk({tag, ".hold_sq"},  64'(sum_sq),  64'(e_sq));
      chk({tag, ".hold_max"}, 64'(max_val), 64'(e_max));
    end
  endtask

  initial begin
    RST      = 1'b1;
    start    = 1'b0;
    bank     = 1'b0;
    side_log = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;

    repeat (3) @(posedge CLK);
    #1;
    chk_zero("reset");
    @(negedge CLK);
    RST = 1'b0;

    // 2x2 grid in bank 1: words 8,24,9,25 = 3,0,5,1.
    mem[8] = 8'd3; mem[24] = 8'd0; mem[9] = 8'd5; mem[25] = 8'd1;
    scan(1, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, "s1");
    chk("s1.occ_plan",    64'(occ_cnt), 64'd3);
    chk("s1.sum_plan",    64'(sum),     64'd9);
    chk("s1.sum_sq_plan", 64'(sum_sq),  64'd35);

    // Full 8x8 grid of saturated counts in bank 0.
    for (int x = 0; x < 8; x++)
      for (int y = 0; y < 8; y++)
        mem[(x << (BI+1)) | y] = 8'd255;
    scan(3, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, "full");
    chk("full.occ_plan",    64'(occ_cnt), 64'd64);
    chk("full.sum_plan",    64'(sum),     64'd16320);
    chk("full.sum_sq_plan", 64'(sum_sq),  64'd4161600);

    // Single-box grid with a zero count.
    mem[8] = 8'd0;
    scan(0, 1'b1, 0, 1'b0, 1'b0, 0, 1'b0, "s0");

    // Oversized side_log clamps to the full grid; a stray start in cycle 10 is ignored.
    for (int i = 0; i < (1 << AW); i++) mem[i] = DL'($urandom_range(0, 255));
    scan(7, 1'b1, 10, 1'b0, 1'b0, 0, 1'b0, "clamp");

    // Reset in cycle 5 of a 4x4 scan, then a clean restart.
    @(negedge CLK);
    side_log = 2; bank = 1'b0; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int c = 1; c < 5; c++) begin
      @(posedge CLK); #1;
    end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk_zero("midrst");
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      chk("midrst.no_done", 64'(done), 64'd0);
      chk("midrst.no_busy", 64'(busy), 64'd0);
    end
    scan(2, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0, "after_rst");

    // Back-to-back: second scan starts in the first scan's done cycle.
    for (int i = 0; i < (1 << AW); i++) mem[i] = DL'($urandom_range(1, 255));
    scan(2, 1'b0, 0, 1'b0, 1'b1, 1, 1'b1, "b2b_a");
    scan(1, 1'b1, 0, 1'b1, 1'b0, 0, 1'b0, "b2b_b");

    // Random grids, banks and sizes, with some zero counts mixed in.
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < (1 << AW); i++)
        mem[i] = ($urandom_range(0, 3) == 0) ? '0 : DL'($urandom);
      scan(int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), 0, 1'b0, 1'b0, 0, 1'b0,
           $sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bc_moment_acc.md
Name: bc_moment_acc

Overview:
- Downstream consumer of the box-count grid built by the quad-sum stage in the multifractal-analysis (box-counting) datapath.
- After each coarsening pass, scans one bank of the box-count RAM for a 2^s x 2^s grid and accumulates the partition-function statistics per level:
  - occupied-box count
  - sum of counts
  - sum of squared counts
- Results are held for the host/log-fit stage until the next start.

Parameters:
- BOX_IDX, 3, log2 of maximum grid side; RAM address is {x[BOX_IDX-1:0], bank, y[BOX_IDX-1:0]}
- DATA_LEN, 8, width of one box count
- OCC_LEN, 2*BOX_IDX+1, width of occupied-box counter

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a scan; ignored while busy=1
- bank  input  1  RAM bank to scan, placed in address bit BOX_IDX
- side_log  input  BOX_IDX+1  s = log2 of grid side; values > BOX_IDX clamped to BOX_IDX
- rd_addr  output  2*BOX_IDX+1  box-count RAM read address
- rd_data  input  DATA_LEN  RAM read data, valid one cycle after rd_addr
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse when results are final
- occ_cnt  output  OCC_LEN  number of boxes with nonzero count
- sum  output  DATA_LEN+2*BOX_IDX  sum of counts
- sum_sq  output  2*DATA_LEN+2*BOX_IDX  sum of squared counts
- max_val  output  DATA_LEN  largest count seen (see Optional Feature)

Behaviour:
- Reset: RST high at a rising edge forces state IDLE and zeroes busy, done, rd_addr, occ_cnt, sum, sum_sq, max_val and all counters. Applies mid-scan with no completion and no done pulse.
- Timing convention: cycle 0 is the cycle in which start=1 is sampled.
- States:
  - IDLE: busy=0. On start=1, latch bank and clamped s, clear all accumulators, go to READ.
  - READ: busy=1. Issue one address per cycle for cycles 1..N, where N = 4^s.
    - Scan order is raster: x fastest 0..2^s-1, then y 0..2^s-1.
    - rd_addr = {x, latched bank, y}; upper x/y bits are zero when s < BOX_IDX.
    - After address N is issued, go to DRAIN.
  - DRAIN: busy=1. Accumulate the final datum (cycle N+1), then go to DONE.
  - DONE: busy=0, done=1 for exactly cycle N+2, then return to IDLE.
- Data pipeline:
  - A 1-bit valid register tracks rd_data.
  - rd_data in cycle k+1 belongs to the address issued in cycle k and is accumulated at the end of cycle k+1.
- Accumulation (all unsigned, zero-extended, no saturation):
  - sum += d
  - sum_sq += d*d
  - occ_cnt += (d != 0)
- Widths: widths cover the worst case; no overflow is possible:
  - N max = 2^(2*BOX_IDX)
  - d max = 2^DATA_LEN - 1
- s = 0 case: N = 1, single address {0, bank, 0}; done in cycle 3.
- Output hold: outputs change only while busy and hold their final values after done until the next accepted start. Outputs clear in the cycle after start is accepted.
- start in the done cycle is accepted; that is the back-to-back case and the new scan begins.
- start while busy=1 is ignored with no effect.
- rd_addr holds its last value outside READ.

Optional Feature:
- Macro BC_MAX_TRACK_EN.
- Defined: max_val register tracks max(d) over the scan. It is cleared on accepted start and held after done; reset value is 0.
- Undefined: no max register is built; max_val is tied to 0.
- All other behaviour is identical in both builds.

Test Plan:
- Defaults, bank=1, side_log=1, RAM words 8,24,9,25 = 3,0,5,1:
  - rd_addr sequence 8,24,9,25 in cycles 1..4
  - done in cycle 6 with occ_cnt=3, sum=9, sum_sq=35
  - max_val=5 (BC_MAX_TRACK_EN) or 0 (without it)
- side_log=3, bank=0, all 64 words = 255:
  - occ_cnt=64, sum=16320, sum_sq=4161600
  - done in cycle 66
- side_log=0, bank=1, word 8 = 0:
  - single read at address 8
  - done in cycle 3 with all results 0
- side_log=7 (clamped to 3):
  - 64 reads, done in cycle 66
  - start pulsed again in cycle 10 is ignored; only one done pulse
- RST asserted in cycle 5 of a side_log=2 scan:
  - next cycle all outputs 0, busy=0, no done
  - new start then completes normally in cycle 18
- start asserted in the done cycle of the first scan:
  - second scan begins immediately and results clear in the next cycle
